// File: rtl/axi_master.sv
// AXI-style burst initiator: one read or write burst per command; read beats reach rd_* one cycle after R handshake.
// Valids hold until their ready; any handshake stalled for TIMEOUT cycles aborts the burst with err.
module axi_master #(
  parameter int TIMEOUT = 64,
  parameter int TCW     = 7
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_burst,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [15:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  input  logic        rlast,
  input  logic        rresp,
  output logic [4:0]  awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [15:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic        bresp
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     addr_q, addr_d;
  logic [3:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [4:0]     beats_total_q, beats_total_d;
  logic [4:0]     beat_cnt_q, beat_cnt_d;
  logic [4:0]     beats_loaded_q, beats_loaded_d;
  logic [15:0]    wbuf_q, wbuf_d;
  logic           wbuf_full_q, wbuf_full_d;
  logic           wbuf_last_q, wbuf_last_d;
  logic           err_flag_q, err_flag_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           arvalid_q, arvalid_d;
  logic           awvalid_q, awvalid_d;
  logic [15:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic           cmd_ready_q, cmd_ready_d;

  logic ar_hs, r_hs, aw_hs, wr_hs, w_hs, b_hs, any_hs, waiting, tout, cnt_last;

  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) & err_flag_q;
  assign rready    = (state_q == RDATA);
  assign bready    = (state_q == WRESP);
  assign wr_ready  = (state_q == WDATA) & ~wbuf_full_q & (beats_loaded_q < beats_total_q);
  assign wvalid    = wbuf_full_q;
  assign wlast     = wbuf_full_q & wbuf_last_q;
  assign wdata     = wbuf_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign arvalid   = arvalid_q;
  assign awvalid   = awvalid_q;
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = size_q;
  assign arburst   = burst_q;
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = size_q;
  assign awburst   = burst_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    beats_total_d  = beats_total_q;
    beat_cnt_d     = beat_cnt_q;
    beats_loaded_d = beats_loaded_q;
    wbuf_d         = wbuf_q;
    wbuf_full_d    = wbuf_full_q;
    wbuf_last_d    = wbuf_last_q;
    err_flag_d     = err_flag_q;
    arvalid_d      = arvalid_q;
    awvalid_d      = awvalid_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    rd_last_d      = 1'b0;

    ar_hs    = arvalid_q & arready;
    r_hs     = rready & rvalid;
    aw_hs    = awvalid_q & awready;
    wr_hs    = wr_valid & wr_ready;
    w_hs     = wbuf_full_q & wready;
    b_hs     = bready & bvalid;
    any_hs   = ar_hs | r_hs | aw_hs | wr_hs | w_hs | b_hs;
    waiting  = state_q inside {RADDR, RDATA, WADDR, WDATA, WRESP};
    tout     = waiting & ~any_hs & (tcnt_q == TCW'(TIMEOUT - 1));
    cnt_last = ((beat_cnt_q + 5'd1) == beats_total_q);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d         = cmd_addr;
          len_d          = cmd_len;
          size_d         = cmd_size;
          burst_d        = cmd_burst;
          beats_total_d  = {1'b0, cmd_len} + 5'd1;
          beat_cnt_d     = 5'd0;
          beats_loaded_d = 5'd0;
          arvalid_d      = ~cmd_write;
          awvalid_d      = cmd_write;
          state_d        = cmd_write ? WADDR : RADDR;
        end
      end
      RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rd_data_d  = rdata;
          rd_valid_d = 1'b1;
          beat_cnt_d = beat_cnt_q + 5'd1;
          // A mismatch between rlast and our own count is a protocol error either way.
          if (!rresp || (rlast != cnt_last)) err_flag_d = 1'b1;
          if (rlast || cnt_last) begin
            rd_last_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          state_d   = WDATA;
        end
      end
      WDATA: begin
        if (w_hs) begin
          wbuf_full_d = 1'b0;
          beat_cnt_d  = beat_cnt_q + 5'd1;
          if (wbuf_last_q) state_d = WRESP;
        end
        if (wr_hs) begin
          wbuf_d         = wr_data;
          wbuf_full_d    = 1'b1;
          wbuf_last_d    = ((beats_loaded_q + 5'd1) == beats_total_q);
          beats_loaded_d = beats_loaded_q + 5'd1;
        end
      end
      WRESP: begin
        if (b_hs) begin
          if (!bresp) err_flag_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        err_flag_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tout) begin
      state_d     = DONE;
      err_flag_d  = 1'b1;
      arvalid_d   = 1'b0;
      awvalid_d   = 1'b0;
      wbuf_full_d = 1'b0;
    end

    tcnt_d      = (!waiting || any_hs || (state_d != state_q)) ? '0 : tcnt_q + TCW'(1);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      beats_total_q  <= '0;
      beat_cnt_q     <= '0;
      beats_loaded_q <= '0;
      wbuf_q         <= '0;
      wbuf_full_q    <= 1'b0;
      wbuf_last_q    <= 1'b0;
      err_flag_q     <= 1'b0;
      tcnt_q         <= '0;
      arvalid_q      <= 1'b0;
      awvalid_q      <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      cmd_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      size_q         <= size_d;
      burst_q        <= burst_d;
      beats_total_q  <= beats_total_d;
      beat_cnt_q     <= beat_cnt_d;
      beats_loaded_q <= beats_loaded_d;
      wbuf_q         <= wbuf_d;
      wbuf_full_q    <= wbuf_full_d;
      wbuf_last_q    <= wbuf_last_d;
      err_flag_q     <= err_flag_d;
      tcnt_q         <= tcnt_d;
      arvalid_q      <= arvalid_d;
      awvalid_q      <= awvalid_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      rd_last_q      <= rd_last_d;
      cmd_ready_q    <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// Bench for axi_master: behavioural slave memory, table of directed bursts, reset abort, random bursts.
module tb_axi_master;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0, res_n = 1'b0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [4:0] cmd_addr = 0;
  logic [3:0] cmd_len = 0;
  logic [2:0] cmd_size = 0;
  logic [1:0] cmd_burst = 0;
  logic [15:0] wr_data = 0, rd_data, rdata = 0, wdata;
  logic wr_valid = 0, wr_ready, rd_valid, rd_last, busy, done, err;
  logic [4:0] araddr, awaddr;
  logic [3:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, arready = 0, rvalid = 0, rready, rlast = 0, rresp = 0;
  logic awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready, bresp = 0;

  always #5 clk = ~clk;

  axi_master #(.TIMEOUT(TIMEOUT), .TCW(7)) dut (
    .clk(clk), .res_n(res_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'h1111;
      2: return 16'h2222;
      3: return 16'h1234;
      4: return 16'h7890;
      5: return 16'h1111;
      default: return 16'(i * 16'h0101);
    endcase
  endfunction

  // Slave knobs, written only by the stimulus process.
  bit stall_en = 0, ar_block = 0, bresp_bad = 0;
  int early_last = -1;

  // Behavioural slave: drives its inputs at negedge, so what it sees now is what the next posedge samples.
  logic [15:0] sl_mem [32];
  bit          sl_init = 0, r_act = 0, w_act = 0, b_pend = 0;
  logic [4:0]  r_addr, w_addr;
  logic [3:0]  r_len;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_burst, w_burst;
  int          r_beat = 0, w_beats = 0, wlast_cnt = 0, wlast_at = 0, ar_hi = 0;

  function automatic bit go();
    return !stall_en || ($urandom_range(3) != 0);
  endfunction

  always @(negedge clk) begin
    if (!sl_init) begin
      for (int i = 0; i < 32; i++) sl_mem[i] = init_val(i);
      sl_init = 1;
    end
    if (!res_n) begin
      arready = 0; rvalid = 0; rlast = 0; rdata = 0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      r_act = 0; w_act = 0; b_pend = 0;
    end else begin
      rvalid = 0; rlast = 0;
      if (r_act && go()) begin
        rvalid = 1;
        rresp  = 1;
        rdata  = (r_size == 3'd0) ? (sl_mem[r_addr] & 16'hFF00) : sl_mem[r_addr];
        rlast  = (r_beat == int'(r_len)) || (r_beat == early_last);
        if (rready) begin
          r_beat++;
          if (r_burst == 2'b01) r_addr = r_addr + 5'd1;
          if (rlast) r_act = 0;
        end
      end
      if (arvalid) ar_hi++;
      arready = arvalid && !ar_block && go();
      if (arvalid && arready) begin
        r_act = 1; r_addr = araddr; r_len = arlen; r_size = arsize; r_burst = arburst; r_beat = 0;
      end
      bvalid = b_pend && go();
      bresp  = !bresp_bad;
      if (bvalid && bready) b_pend = 0;
      wready = w_act && go();
      if (wvalid && wready) begin
        w_beats++;
        if (w_size == 3'd0) sl_mem[w_addr] = {wdata[15:8], sl_mem[w_addr][7:0]};
        else                sl_mem[w_addr] = wdata;
        if (w_burst == 2'b01) w_addr = w_addr + 5'd1;
        if (wlast) begin wlast_cnt++; wlast_at = w_beats; w_act = 0; b_pend = 1; end
      end
      awready = awvalid && go();
      if (awvalid && awready) begin
        w_act = 1; w_addr = awaddr; w_size = awsize; w_burst = awburst;
      end
    end
  end

  // Reference memory: what the slave should hold if every burst behaved.
  logic [15:0] ref_mem [32];
  logic [15:0] got_rd [$];

  task automatic run_cmd(input bit wr, input logic [4:0] a, input logic [3:0] l, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [15:0] base, input bit rnd, input int gap,
                         input bit exp_err, input int exp_beats, input string tag);
    logic [15:0] wq [$];
    logic [15:0] exp_q [$];
    logic [15:0] d;
    logic [4:0]  ea;
    int w0, wl0, idx, gapc, cyc, last_pos, n_last;
    bit acc, got_done, got_err;
    got_rd.delete();
    for (int i = 0; i <= int'(l); i++) wq.push_back(rnd ? 16'($urandom) : base + 16'(i));
    ea = a;
    for (int i = 0; i < exp_beats; i++) begin
      exp_q.push_back(sz == 3'd0 ? (ref_mem[ea] & 16'hFF00) : ref_mem[ea]);
      if (bu == 2'b01) ea = ea + 5'd1;
    end
    w0 = w_beats; wl0 = wlast_cnt;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = sz; cmd_burst = bu;
    acc = 0; got_done = 0; got_err = 0; idx = 0; gapc = 0; cyc = 0; last_pos = -1; n_last = 0;
    while (!got_done && cyc < 600) begin
      if (acc) cmd_valid = 0;
      if (rd_valid) begin
        got_rd.push_back(rd_data);
        if (rd_last) begin n_last++; last_pos = got_rd.size() - 1; end
      end
      if (done) begin got_done = 1; got_err = err; end
      if (wr && idx < wq.size() && gapc == 0) begin wr_valid = 1; wr_data = wq[idx]; end
      else begin wr_valid = 0; if (gapc > 0) gapc--; end
      if (wr_valid && wr_ready) begin idx++; gapc = gap; end
      if (cmd_valid && cmd_ready) acc = 1;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 0; wr_valid = 0;
    chk($sformatf("%s done", tag), got_done, 1);
    chk($sformatf("%s err", tag), got_err, exp_err);
    chk($sformatf("%s idle_after", tag), {busy, cmd_ready}, 2'b01);
    if (wr) begin
      chk($sformatf("%s w_beats", tag), w_beats - w0, exp_beats);
      chk($sformatf("%s wlast_cnt", tag), wlast_cnt - wl0, 1);
      chk($sformatf("%s wlast_pos", tag), wlast_at - w0, exp_beats);
      ea = a;
      foreach (wq[i]) begin
        d = wq[i];
        ref_mem[ea] = (sz == 3'd0) ? {d[15:8], ref_mem[ea][7:0]} : d;
        if (bu == 2'b01) ea = ea + 5'd1;
      end
    end else begin
      chk($sformatf("%s rd_beats", tag), got_rd.size(), exp_beats);
      for (int i = 0; i < exp_q.size() && i < got_rd.size(); i++)
        chk($sformatf("%s rd%0d", tag, i), got_rd[i], exp_q[i]);
      chk($sformatf("%s rd_last_cnt", tag), n_last, (exp_beats > 0) ? 1 : 0);
      if (exp_beats > 0) chk($sformatf("%s rd_last_pos", tag), last_pos, exp_beats - 1);
    end
  endtask

  typedef struct {
    bit wr; logic [4:0] a; logic [3:0] l; logic [2:0] sz; logic [1:0] bu; logic [15:0] base;
    int gap; int early; bit ar_blk; bit bbad; bit exp_err; int exp_beats;
  } vec_t;

  vec_t        tbl [11];
  logic [15:0] t2 [6];
  int          ar0, w0, cyc;

  initial begin
    tbl[0]  = '{0, 5'd0,  4'd5,  3'd1, 2'b01, 16'h0000, 0, -1, 0, 0, 0, 6};
    tbl[1]  = '{0, 5'd3,  4'd2,  3'd0, 2'b00, 16'h0000, 0, -1, 0, 0, 0, 3};
    tbl[2]  = '{1, 5'd2,  4'd3,  3'd1, 2'b01, 16'hA001, 0, -1, 0, 0, 0, 4};
    tbl[3]  = '{0, 5'd2,  4'd3,  3'd1, 2'b01, 16'h0000, 0, -1, 0, 0, 0, 4};
    tbl[4]  = '{1, 5'd10, 4'd0,  3'd1, 2'b01, 16'h5A5A, 0, -1, 0, 0, 0, 1};
    tbl[5]  = '{1, 5'd12, 4'd3,  3'd1, 2'b01, 16'hB001, 5, -1, 0, 0, 0, 4};
    tbl[6]  = '{0, 5'd12, 4'd3,  3'd1, 2'b01, 16'h0000, 0, -1, 0, 0, 0, 4};
    tbl[7]  = '{0, 5'd0,  4'd1,  3'd1, 2'b01, 16'h0000, 0, -1, 1, 0, 1, 0};
    tbl[8]  = '{0, 5'd0,  4'd3,  3'd1, 2'b01, 16'h0000, 0,  1, 0, 0, 1, 2};
    tbl[9]  = '{1, 5'd16, 4'd1,  3'd1, 2'b01, 16'hC001, 0, -1, 0, 1, 1, 2};
    tbl[10] = '{0, 5'd16, 4'd15, 3'd1, 2'b01, 16'h0000, 0, -1, 0, 0, 0, 16};
    t2 = '{16'hFFFF, 16'h1111, 16'h2222, 16'h1234, 16'h7890, 16'h1111};
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    repeat (3) @(negedge clk);
    chk("reset ctl", {cmd_ready, busy, done, err, rd_valid, arvalid, awvalid, wvalid, wr_ready, rready, bready}, 0);
    res_n = 1;
    @(negedge clk);
    chk("post_reset cmd_ready", cmd_ready, 1);
    chk("post_reset busy", busy, 0);

    for (int i = 0; i < 11; i++) begin
      early_last = tbl[i].early; ar_block = tbl[i].ar_blk; bresp_bad = tbl[i].bbad;
      ar0 = ar_hi;
      run_cmd(tbl[i].wr, tbl[i].a, tbl[i].l, tbl[i].sz, tbl[i].bu, tbl[i].base, 0, tbl[i].gap,
              tbl[i].exp_err, tbl[i].exp_beats, $sformatf("v%0d", i));
      if (i == 0) for (int k = 0; k < 6 && k < got_rd.size(); k++) chk($sformatf("init_rd%0d", k), got_rd[k], t2[k]);
      if (i == 1) for (int k = 0; k < got_rd.size(); k++) chk($sformatf("fixbyte_rd%0d", k), got_rd[k], 16'h1200);
      if (i == 3) for (int k = 0; k < got_rd.size(); k++) chk($sformatf("readback_rd%0d", k), got_rd[k], 16'hA001 + 16'(k));
      if (i == 7) chk("timeout arvalid_cycles", ar_hi - ar0, TIMEOUT);
    end
    early_last = -1; ar_block = 0; bresp_bad = 0;

    // Reset in the middle of a write burst, after the first W beat.
    w0 = w_beats; cyc = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 5'd20; cmd_len = 4'd3; cmd_size = 3'd1; cmd_burst = 2'b01;
    wr_valid = 1; wr_data = 16'hDEAD;
    @(negedge clk);
    cmd_valid = 0;
    while ((w_beats - w0) < 1 && cyc < 200) begin @(posedge clk); cyc++; end
    chk("rst_mid wait_beat1", (w_beats - w0) >= 1, 1);
    @(negedge clk);
    res_n = 0; wr_valid = 0;
    #1;
    chk("rst_mid ctl", {cmd_ready, busy, done, err, rd_valid, rd_last, arvalid, rready, awvalid, wvalid, wlast, wr_ready, bready}, 0);
    chk("rst_mid data", {rd_data, wdata, araddr, arlen, arsize, arburst}, 0);
    repeat (2) @(negedge clk);
    res_n = 1;
    @(negedge clk);
    chk("rst_release cmd_ready", cmd_ready, 1);
    run_cmd(0, 5'd0, 4'd1, 3'd1, 2'b01, 16'h0, 0, 0, 0, 2, "after_rst_rd");
    run_cmd(1, 5'd20, 4'd3, 3'd1, 2'b01, 16'hD001, 0, 0, 0, 4, "resync_wr");

    stall_en = 1;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] l;
      l = 4'($urandom_range(15));
      run_cmd(1'($urandom_range(1)), 5'($urandom_range(31)), l, 3'($urandom_range(1)),
              2'($urandom_range(1)), 16'h0, 1, $urandom_range(2), 0, int'(l) + 1, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
